// File: rtl/bcd_stopwatch.sv
// bcd_stopwatch: SS.hh stopwatch core driven by the display multiplexer's 1 ms enable.
// Two raw buttons (start/stop, clear) are synchronised and debounced here; the
// packed-BCD count is registered and fed straight to the multiplexer's dat input.
// dbg_state exposes the FSM state register: 0 = IDLE, 1 = RUN, 2 = STOP.
module bcd_stopwatch #(
    parameter int DEB_MS = 20,
    parameter int DIV    = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ce1ms,
    input  logic        btn_ss,
    input  logic        btn_clr,
    output logic [15:0] dat,
    output logic        running,
    output logic        ovf,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    localparam logic [7:0] L_DEB_LAST = 8'(DEB_MS - 1);
    localparam logic [7:0] L_DIV_LAST = 8'(DIV - 1);

    // Index 0 is start/stop, index 1 is clear.
    logic [1:0]  w_btn;
    logic [1:0]  r_sync1;
    logic [1:0]  r_sync2;
    logic [1:0]  r_deb_lvl;
    logic [7:0]  r_deb_cnt [0:1];
    // r_deb_p[i] is high for exactly one cycle, the cycle after the debounced
    // level of button i rises; a falling level never produces a pulse.
    logic [1:0]  r_deb_p;

    logic        w_ss_p;
    logic        w_clr_p;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_running;

    logic [7:0]  r_div;
    logic        w_run_ce;
    logic        w_tick;
    logic        w_wrap;
    logic [15:0] r_dat;
    logic [15:0] w_dat_inc;
    logic        r_ovf;

    assign w_btn   = {btn_clr, btn_ss};
    assign w_ss_p  = r_deb_p[0];
    assign w_clr_p = r_deb_p[1];

    // Two-flop synchronisers for the asynchronous raw buttons.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_btn;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce: the level flips after DEB_MS consecutive differing 1 ms samples.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_deb_lvl <= '0;
            r_deb_p   <= '0;
            for (int i = 0; i < 2; i++) begin
                r_deb_cnt[i] <= '0;
            end
        end else begin
            r_deb_p <= '0;
            for (int i = 0; i < 2; i++) begin
                if (ce1ms) begin
                    if (r_sync2[i] == r_deb_lvl[i]) begin
                        r_deb_cnt[i] <= '0;
                    end else if (r_deb_cnt[i] == L_DEB_LAST) begin
                        r_deb_lvl[i] <= ~r_deb_lvl[i];
                        r_deb_cnt[i] <= '0;
                        r_deb_p[i]   <= ~r_deb_lvl[i];
                    end else begin
                        r_deb_cnt[i] <= r_deb_cnt[i] + 8'd1;
                    end
                end
            end
        end
    end

    // State register; running is registered alongside the state it reflects.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_running <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_running <= (w_state_nxt == ST_RUN);
        end
    end

    // Next state: clear beats start/stop when both pulse together.
    always_comb begin
        w_state_nxt = r_state;
        if (w_clr_p) begin
            w_state_nxt = ST_IDLE;
        end else if (w_ss_p) begin
            case (r_state)
                ST_IDLE: w_state_nxt = ST_RUN;
                ST_RUN:  w_state_nxt = ST_STOP;
                ST_STOP: w_state_nxt = ST_RUN;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // The tick follows the current state, so a stopping cycle still counts.
    assign w_run_ce = (r_state == ST_RUN) && ce1ms;
    assign w_tick   = w_run_ce && (r_div == L_DIV_LAST);
    assign w_wrap   = (r_dat == 16'h5999);

    // BCD ripple increment: 9 -> 0 carries, tens of seconds wrap after 5.
    always_comb begin
        w_dat_inc = r_dat;
        if (r_dat[3:0] != 4'd9) begin
            w_dat_inc[3:0] = r_dat[3:0] + 4'd1;
        end else begin
            w_dat_inc[3:0] = 4'd0;
            if (r_dat[7:4] != 4'd9) begin
                w_dat_inc[7:4] = r_dat[7:4] + 4'd1;
            end else begin
                w_dat_inc[7:4] = 4'd0;
                if (r_dat[11:8] != 4'd9) begin
                    w_dat_inc[11:8] = r_dat[11:8] + 4'd1;
                end else begin
                    w_dat_inc[11:8] = 4'd0;
                    if (r_dat[15:12] != 4'd5) begin
                        w_dat_inc[15:12] = r_dat[15:12] + 4'd1;
                    end else begin
                        w_dat_inc[15:12] = 4'd0;
                    end
                end
            end
        end
    end

    // Divider and count; the divider value is held while stopped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_div <= '0;
            r_dat <= '0;
            r_ovf <= 1'b0;
        end else if (w_clr_p) begin
            r_div <= '0;
            r_dat <= '0;
            r_ovf <= 1'b0;
        end else if (w_run_ce) begin
            if (w_tick) begin
                r_div <= '0;
                r_dat <= w_dat_inc;
                if (w_wrap) begin
                    r_ovf <= 1'b1;
                end
            end else begin
                r_div <= r_div + 8'd1;
            end
        end
    end

    assign dat       = r_dat;
    assign running   = r_running;
    assign ovf       = r_ovf;
    assign dbg_state = r_state;

endmodule
